// File: rtl/fcvt_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fcvt_ctrl : two-requester round-robin front end for a shared FCVT.W.S unit
// Rev 1.0
// ---------------------------------------------------------------------------
module fcvt_ctrl #(
   parameter int DATA_W  = 32,
   parameter bit RR_INIT = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_op,
   input  logic [DATA_W-1:0] req1_op,
   input  logic [2:0]        req0_rm,
   input  logic [2:0]        req1_rm,
   input  logic [2:0]        frm,
   output logic [DATA_W-1:0] dp_op,
   output logic [2:0]        dp_rm,
   input  logic [DATA_W-1:0] dp_result,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_nv,
   output logic              resp_illegal
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [DATA_W-1:0] INT_MIN_F = 32'hCF000000;

   state_t            state_q, state_d;
   logic              prio_q, prio_d;
   logic              id_q, id_d;
   logic [DATA_W-1:0] op_q, op_d;
   logic [2:0]        rm_q, rm_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              nv_q, nv_d;
   logic              ill_q, ill_d;

   logic [2:0]        eff_rm0, eff_rm1, sel_rm;
   logic [DATA_W-1:0] sel_op;
   logic              can_grant, gnt_id, accept, sel_ill, conv_nv;

   always_comb begin
      eff_rm0   = (req0_rm == 3'b111) ? frm : req0_rm;
      eff_rm1   = (req1_rm == 3'b111) ? frm : req1_rm;
      can_grant = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
      // Contention resolves to the priority holder; a lone requester always wins.
      gnt_id    = (req_valid == 2'b11) ? prio_q : req_valid[1];
      accept    = can_grant && (req_valid != 2'b00);
      sel_op    = gnt_id ? req1_op : req0_op;
      sel_rm    = gnt_id ? eff_rm1 : eff_rm0;
      sel_ill   = (sel_rm >= 3'd5);
      conv_nv   = (op_q[30:23] == 8'hFF) ||
                  ((op_q[30:23] >= 8'h9E) && (op_q != INT_MIN_F));

      state_d = state_q;
      prio_d  = prio_q;
      id_d    = id_q;
      op_d    = op_q;
      rm_d    = rm_q;
      data_d  = data_q;
      nv_d    = nv_q;
      ill_d   = ill_q;

      case (state_q)
         CONV: begin
            data_d  = dp_result;
            nv_d    = conv_nv;
            ill_d   = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         prio_d = ~gnt_id;
         id_d   = gnt_id;
         op_d   = sel_op;
         rm_d   = sel_rm;
         if (sel_ill) begin
            data_d  = '0;
            nv_d    = 1'b0;
            ill_d   = 1'b1;
            state_d = RESP;
         end else begin
            state_d = CONV;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         prio_q  <= RR_INIT;
         id_q    <= 1'b0;
         op_q    <= '0;
         rm_q    <= 3'd0;
         data_q  <= '0;
         nv_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         id_q    <= id_d;
         op_q    <= op_d;
         rm_q    <= rm_d;
         data_q  <= data_d;
         nv_q    <= nv_d;
         ill_q   <= ill_d;
      end
   end

   // Gated by reset_n so ready stays low while reset is held.
   assign req_ready    = (accept && reset_n) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
   assign dp_op        = (state_q == CONV) ? op_q : '0;
   assign dp_rm        = (state_q == CONV) ? rm_q : 3'd0;
   assign resp_valid   = (state_q == RESP);
   assign resp_id      = id_q;
   assign resp_data    = data_q;
   assign resp_nv      = nv_q;
   assign resp_illegal = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_fcvt_ctrl.sv
`default_nettype none
// tb_fcvt_ctrl : directed self-checking bench; a behavioural FCVT.W.S model
// stands in for the shared datapath.
module tb_fcvt_ctrl;

   logic        clk;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req0_op, req1_op;
   logic [2:0]  req0_rm, req1_rm, frm;
   logic [31:0] dp_op;
   logic [2:0]  dp_rm;
   logic [31:0] dp_result;
   logic        resp_valid, resp_ready, resp_id, resp_nv, resp_illegal;
   logic [31:0] resp_data;

   int n_cmp = 0;
   int n_err = 0;

   fcvt_ctrl #(.DATA_W(32), .RR_INIT(1'b0)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_rm(req0_rm), .req1_rm(req1_rm), .frm(frm),
      .dp_op(dp_op), .dp_rm(dp_rm), .dp_result(dp_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data),
      .resp_nv(resp_nv), .resp_illegal(resp_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] fcvt_model(input logic [31:0] f, input logic [2:0] rm);
      logic        s;
      logic [7:0]  e;
      logic [23:0] m;
      logic [63:0] fx;
      logic [31:0] ip, mag;
      logic        half, rest, inc;
      int          sh;
      s = f[31];
      e = f[30:23];
      m = (e == 8'h00) ? {1'b0, f[22:0]} : {1'b1, f[22:0]};
      if (e == 8'hFF) return (f[22:0] != 23'd0 || !s) ? 32'h7FFFFFFF : 32'h80000000;
      if (e >= 8'h9E) return s ? 32'h80000000 : 32'h7FFFFFFF;
      if (e >= 8'd150) begin
         mag = {8'b0, m} << (int'(e) - 150);
         return s ? -mag : mag;
      end
      sh   = 150 - int'(e);
      fx   = {m, 40'b0} >> sh;
      ip   = {8'b0, fx[63:40]};
      half = fx[39];
      rest = |fx[38:0];
      case (rm)
         3'd0:    inc = half & (rest | ip[0]);
         3'd2:    inc = s & (half | rest);
         3'd3:    inc = !s & (half | rest);
         3'd4:    inc = half;
         default: inc = 1'b0;
      endcase
      mag = ip + {31'b0, inc};
      return s ? -mag : mag;
   endfunction

   always_comb dp_result = fcvt_model(dp_op, dp_rm);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Single isolated request with resp_ready held high.
   task automatic do_req(input logic id, input logic [31:0] op, input logic [2:0] rm,
                         input logic [2:0] e_rm, input logic [31:0] e_data,
                         input logic e_nv, input logic e_ill);
      if (id) begin req1_op = op; req1_rm = rm; req_valid = 2'b10; end
      else    begin req0_op = op; req0_rm = rm; req_valid = 2'b01; end
      #1 check("grant", {30'b0, req_ready}, id ? 32'd2 : 32'd1);
      cyc();
      req_valid = 2'b00;
      if (!e_ill) begin
         check("conv_rv", {31'b0, resp_valid}, 32'd0);
         check("dp_op", dp_op, op);
         check("dp_rm", {29'b0, dp_rm}, {29'b0, e_rm});
         cyc();
      end
      check("resp_valid", {31'b0, resp_valid}, 32'd1);
      check("resp_id", {31'b0, resp_id}, {31'b0, id});
      check("resp_data", resp_data, e_data);
      check("resp_nv", {31'b0, resp_nv}, {31'b0, e_nv});
      check("resp_ill", {31'b0, resp_illegal}, {31'b0, e_ill});
      check("resp_dp_op", dp_op, 32'd0);
      cyc();
      check("idle_rv", {31'b0, resp_valid}, 32'd0);
   endtask

   initial begin
      logic [1:0] exp_rdy [1:8];
      exp_rdy = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

      reset_n = 1'b0; req_valid = 2'b11; resp_ready = 1'b1;
      req0_op = 32'd0; req1_op = 32'd0; req0_rm = 3'd0; req1_rm = 3'd0; frm = 3'd0;
      cyc(); cyc();
      check("rst_ready", {30'b0, req_ready}, 32'd0);
      check("rst_rv", {31'b0, resp_valid}, 32'd0);
      check("rst_data", resp_data, 32'd0);
      check("rst_dp_op", dp_op, 32'd0);
      req_valid = 2'b00;
      reset_n = 1'b1;
      cyc();

      // Both requesters continuously valid: alternate grants, one response per two cycles.
      req0_op = 32'h40200000; req1_op = 32'h40400000;
      req_valid = 2'b11;
      #1 check("rr_g0", {30'b0, req_ready}, 32'd1);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         check("rr_ready", {30'b0, req_ready}, {30'b0, exp_rdy[k]});
         check("rr_rv", {31'b0, resp_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
         if (k % 2 == 0) begin
            check("rr_id", {31'b0, resp_id}, (k % 4 == 0) ? 32'd1 : 32'd0);
            check("rr_data", resp_data, (k % 4 == 0) ? 32'd3 : 32'd2);
         end
      end
      req_valid = 2'b00;
      #1 check("rr_drop", {30'b0, req_ready}, 32'd0);
      cyc();
      check("rr_idle", {31'b0, resp_valid}, 32'd0);

      // 2.5 round-to-nearest-even -> 2
      do_req(1'b0, 32'h40200000, 3'd0, 3'd0, 32'd2, 1'b0, 1'b0);

      // Priority now with requester 1; idle cycles must not move it.
      cyc(); cyc();
      req_valid = 2'b11;
      #1 check("prio_hold", {30'b0, req_ready}, 32'd2);
      req_valid = 2'b00;
      cyc();
      check("drop_noeff_rv", {31'b0, resp_valid}, 32'd0);
      check("drop_noeff_dp", dp_op, 32'd0);
      req_valid = 2'b11;
      #1 check("prio_hold2", {30'b0, req_ready}, 32'd2);
      req_valid = 2'b00;
      cyc();

      // Dynamic rm: frm=RUP gives 1.5 -> 2; frm=5 is illegal with one-cycle latency.
      frm = 3'b011;
      do_req(1'b1, 32'h3FC00000, 3'd7, 3'd3, 32'd2, 1'b0, 1'b0);
      frm = 3'b101;
      do_req(1'b1, 32'h3FC00000, 3'd7, 3'd0, 32'd0, 1'b0, 1'b1);
      frm = 3'b000;
      do_req(1'b0, 32'h3FC00000, 3'd6, 3'd0, 32'd0, 1'b0, 1'b1);

      // Invalid-operation boundaries.
      do_req(1'b0, 32'h7FC00000, 3'd0, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
      do_req(1'b0, 32'hCF000000, 3'd1, 3'd1, 32'h80000000, 1'b0, 1'b0);
      do_req(1'b1, 32'h4F000000, 3'd1, 3'd1, 32'h7FFFFFFF, 1'b1, 1'b0);
      do_req(1'b1, 32'hC0200000, 3'd2, 3'd2, 32'hFFFFFFFD, 1'b0, 1'b0);

      // Back-pressure with requester 1 pending.
      resp_ready = 1'b0;
      req0_op = 32'h40200000; req0_rm = 3'd0;
      req1_op = 32'h40400000; req1_rm = 3'd0;
      req_valid = 2'b01;
      #1 check("bp_grant", {30'b0, req_ready}, 32'd1);
      cyc();
      req_valid = 2'b10;
      #1 check("bp_conv_rdy", {30'b0, req_ready}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         check("bp_rv", {31'b0, resp_valid}, 32'd1);
         check("bp_id", {31'b0, resp_id}, 32'd0);
         check("bp_data", resp_data, 32'd2);
         check("bp_nv", {31'b0, resp_nv}, 32'd0);
         check("bp_ready", {30'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      #1 check("bp_release", {30'b0, req_ready}, 32'd2);
      cyc();
      req_valid = 2'b00;
      check("bp_conv1_rv", {31'b0, resp_valid}, 32'd0);
      cyc();
      check("bp_resp1_id", {31'b0, resp_id}, 32'd1);
      check("bp_resp1_data", resp_data, 32'd3);
      cyc();

      // Reset during CONV discards the conversion and restores RR_INIT priority.
      req_valid = 2'b01;
      cyc();
      req_valid = 2'b00;
      check("pre_rst_dp", dp_op, 32'h40200000);
      reset_n = 1'b0;
      #1;
      check("mid_rst_dp_op", dp_op, 32'd0);
      check("mid_rst_dp_rm", {29'b0, dp_rm}, 32'd0);
      check("mid_rst_rv", {31'b0, resp_valid}, 32'd0);
      check("mid_rst_data", resp_data, 32'd0);
      check("mid_rst_id", {31'b0, resp_id}, 32'd0);
      cyc();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("post_rst_rv", {31'b0, resp_valid}, 32'd0);
      end
      req_valid = 2'b11;
      #1 check("post_rst_prio", {30'b0, req_ready}, 32'd1);
      req_valid = 2'b00;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
